// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern generator: sequence encoding,
// colour-mask bit positions, switch/button bit roles and the prescaler limit formula.
package led_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_SR   = 2'b00,
    SEQ_FS   = 2'b01,
    SEQ_SR2L = 2'b10
  } seq_e;

  // The colour mask is i_btn[3:1], so colour bit k belongs to button k+1
  localparam int COL_R = 0;
  localparam int COL_G = 1;
  localparam int COL_B = 2;
  localparam logic [2:0] COLOUR_RESET = 3'b001;

  localparam int BTN_NEXT = 0;
  localparam int SW_EN    = 0;
  localparam int SW_DIR   = 3;

  // Terminal count for rate select k: 2^(nCount-10+k) - 1 (nCount between 10 and 32)
  function automatic logic [31:0] limitFor(input int nCount, input logic [1:0] rate);
    return (32'd1 << (nCount - 10 + int'(rate))) - 32'd1;
  endfunction

endpackage

// File: rtl/led_seq_if.sv
// Board-side bundle of the LED generator: switch/button inputs and the four LED banks.
interface led_seq_if #(
  parameter int n_SW   = 4,
  parameter int n_BTN  = 4,
  parameter int n_LEDS = 4
);
  logic [n_SW-1:0]   i_sw;
  logic [n_BTN-1:0]  i_btn;
  logic [n_LEDS-1:0] o_led;
  logic [n_LEDS-1:0] o_led_r;
  logic [n_LEDS-1:0] o_led_g;
  logic [n_LEDS-1:0] o_led_b;

  modport master (
    output i_sw, i_btn,
    input  o_led, o_led_r, o_led_g, o_led_b
  );

  modport slave (
    input  i_sw, i_btn,
    output o_led, o_led_r, o_led_g, o_led_b
  );
endinterface

// File: rtl/led_seq_tick_counter.sv
// Prescaler: free-running counter with a switch-selected limit; emits a one-cycle step tick.
module led_seq_tick_counter
  import led_seq_pkg::*;
#(
  parameter int n_COUNT = 32
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [1:0] i_rate,
  output logic       o_tick
);

  logic [n_COUNT-1:0] r_count;
  logic [n_COUNT-1:0] w_limit;
  logic               w_hit;

  // >= rather than == so that lowering the rate while above the new limit fires at once
  assign w_limit = n_COUNT'(limitFor(n_COUNT, i_rate));
  assign w_hit   = i_en && (r_count >= w_limit);
  assign o_tick  = w_hit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_en) begin
      if (w_hit) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + n_COUNT'(1);
      end
    end
  end

endmodule

// File: rtl/led_seq_top.sv
// LED pattern generator top (SR / FS / SR2L patterns, colour-gated RGB banks).
// Optional LED_SEQ_INPUT_SYNC_EN adds a 2-flop synchroniser on i_sw/i_btn.
module led_seq_top
  import led_seq_pkg::*;
#(
  parameter int n_SW    = 4,
  parameter int n_BTN   = 4,
  parameter int n_LEDS  = 4,
  parameter int n_COUNT = 32
) (
  input  logic     i_clk,
  input  logic     i_reset,
  led_seq_if.slave bus
);

  localparam int HALF = n_LEDS / 2;
  localparam logic [n_LEDS-1:0] SEED_SR   = {{(n_LEDS-1){1'b0}}, 1'b1};
  localparam logic [n_LEDS-1:0] SEED_FS   = '1;
  localparam logic [n_LEDS-1:0] SEED_SR2L = {1'b1, {(n_LEDS-2){1'b0}}, 1'b1};

  logic [n_SW-1:0]   w_sw;
  logic [n_BTN-1:0]  w_btn;
  logic [n_BTN-1:0]  r_btn_q;
  logic [n_BTN-1:0]  w_rise;
  logic              w_tick;

  seq_e              r_seq, w_seq_next;
  logic [n_LEDS-1:0] r_pattern, w_pattern_next;
  logic [2:0]        r_colour, w_colour_next;
  logic [n_LEDS-1:0] r_led_r, r_led_g, r_led_b;

  logic [HALF-1:0]   w_half, w_half_next;
  logic [n_LEDS-1:0] w_pair_next;

`ifdef LED_SEQ_INPUT_SYNC_EN
  logic [n_SW-1:0]  r_sw_meta, r_sw_sync;
  logic [n_BTN-1:0] r_btn_meta, r_btn_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_btn_meta <= '0;
      r_btn_sync <= '0;
    end else begin
      r_sw_meta  <= bus.i_sw;
      r_sw_sync  <= r_sw_meta;
      r_btn_meta <= bus.i_btn;
      r_btn_sync <= r_btn_meta;
    end
  end

  assign w_sw  = r_sw_sync;
  assign w_btn = r_btn_sync;
`else
  assign w_sw  = bus.i_sw;
  assign w_btn = bus.i_btn;
`endif

  assign w_rise = w_btn & ~r_btn_q;

  led_seq_tick_counter #(.n_COUNT(n_COUNT)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_sw[SW_EN]),
    .i_rate  (w_sw[2:1]),
    .o_tick  (w_tick)
  );

  // SR2L is symmetric, so step the lower half (bit 0 = outermost) and mirror it upward
  always_comb begin
    w_half      = r_pattern[HALF-1:0];
    w_half_next = w_half;
    if (w_sw[SW_DIR]) begin
      if (w_half[0]) w_half_next = {1'b1, {(HALF-1){1'b0}}};
      else           w_half_next = w_half >> 1;
    end else begin
      if (w_half[HALF-1]) w_half_next = {{(HALF-1){1'b0}}, 1'b1};
      else                w_half_next = w_half << 1;
    end
    w_pair_next = '0;
    for (int i = 0; i < HALF; i++) begin
      w_pair_next[i]          = w_half_next[i];
      w_pair_next[n_LEDS-1-i] = w_half_next[i];
    end
  end

  // A sequence press reseeds and overrides a coincident tick
  always_comb begin
    w_seq_next     = r_seq;
    w_pattern_next = r_pattern;
    w_colour_next  = r_colour;
    if (w_rise[BTN_NEXT]) begin
      case (r_seq)
        SEQ_SR: begin
          w_seq_next     = SEQ_FS;
          w_pattern_next = SEED_FS;
        end
        SEQ_FS: begin
          w_seq_next     = SEQ_SR2L;
          w_pattern_next = SEED_SR2L;
        end
        default: begin
          w_seq_next     = SEQ_SR;
          w_pattern_next = SEED_SR;
        end
      endcase
    end else if (w_tick) begin
      case (r_seq)
        SEQ_SR: begin
          if (w_sw[SW_DIR]) w_pattern_next = {r_pattern[n_LEDS-2:0], r_pattern[n_LEDS-1]};
          else              w_pattern_next = {r_pattern[0], r_pattern[n_LEDS-1:1]};
        end
        SEQ_FS:  w_pattern_next = ~r_pattern;
        default: w_pattern_next = w_pair_next;
      endcase
    end
    if (|w_rise[3:1]) begin
      w_colour_next = w_btn[3:1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_seq     <= SEQ_SR;
      r_pattern <= SEED_SR;
      r_colour  <= COLOUR_RESET;
      r_btn_q   <= '0;
      r_led_r   <= SEED_SR;
      r_led_g   <= '0;
      r_led_b   <= '0;
    end else begin
      r_seq     <= w_seq_next;
      r_pattern <= w_pattern_next;
      r_colour  <= w_colour_next;
      r_btn_q   <= w_btn;
      r_led_r   <= w_pattern_next & {n_LEDS{w_colour_next[COL_R]}};
      r_led_g   <= w_pattern_next & {n_LEDS{w_colour_next[COL_G]}};
      r_led_b   <= w_pattern_next & {n_LEDS{w_colour_next[COL_B]}};
    end
  end

  assign bus.o_led   = r_pattern;
  assign bus.o_led_r = r_led_r;
  assign bus.o_led_g = r_led_g;
  assign bus.o_led_b = r_led_b;

endmodule

// File: tb/tb_led_seq_top.sv
// Scoreboard bench for led_seq_top (n_COUNT=13, 4 LEDs): stimulus queues hand-computed
// expectations tagged with a clock edge; a monitor pops and compares them at that edge.
module tb_led_seq_top;

  typedef struct {
    int         cyc;
    logic [3:0] led;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   edgeCount = 0;
  int   checks = 0;
  int   passes = 0;
  int   base = 0;
  exp_t expQ[$];
  exp_t monE;

  led_seq_if #(.n_SW(4), .n_BTN(4), .n_LEDS(4)) bus ();

  led_seq_top #(.n_SW(4), .n_BTN(4), .n_LEDS(4), .n_COUNT(13)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input exp_t e);
    logic [15:0] act;
    logic [15:0] req;
    act = {bus.o_led, bus.o_led_r, bus.o_led_g, bus.o_led_b};
    req = {e.led, e.r, e.g, e.b};
    checks++;
    if (e.cyc != edgeCount) begin
      $display("[TB] FAIL %s: checked at edge %0d, scheduled for edge %0d", e.name, edgeCount, e.cyc);
    end else if (act !== req) begin
      $display("[TB] FAIL %s @edge %0d: led/r/g/b got %b/%b/%b/%b want %b/%b/%b/%b",
               e.name, edgeCount, act[15:12], act[11:8], act[7:4], act[3:0],
               req[15:12], req[11:8], req[7:4], req[3:0]);
    end else begin
      passes++;
    end
  endtask

  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= edgeCount) begin
      monE = expQ.pop_front();
      checkOutput(monE);
    end
  end

  task automatic expectAt(input int cyc, input logic [3:0] led, input logic [3:0] r,
                          input logic [3:0] g, input logic [3:0] b, input string name);
    exp_t e;
    e.cyc = cyc; e.led = led; e.r = r; e.g = g; e.b = b; e.name = name;
    expQ.push_back(e);
  endtask

  task automatic expectR(input int cyc, input logic [3:0] led, input string name);
    expectAt(cyc, led, led, 4'b0000, 4'b0000, name);
  endtask

  task automatic waitEdge(input int target);
    while (edgeCount < target) @(negedge clk);
  endtask

  task automatic applyStimulus(input int atEdge, input logic [3:0] sw, input logic [3:0] btn,
                               input logic rst);
    waitEdge(atEdge);
    bus.i_sw  = sw;
    bus.i_btn = btn;
    reset     = rst;
  endtask

  task automatic startScenario(input logic [3:0] sw);
    @(negedge clk);
    bus.i_sw  = sw;
    bus.i_btn = 4'b0000;
    reset     = 1'b1;
    base      = edgeCount + 1;
  endtask

  task automatic drain();
    exp_t e;
    for (int i = 0; i < 400 && expQ.size() > 0; i++) @(negedge clk);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      $display("[TB] FAIL %s: never reached (scheduled edge %0d, now %0d)", e.name, e.cyc, edgeCount);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    bus.i_sw  = 4'b0000;
    bus.i_btn = 4'b0000;
    $display("[TB] start");

    // Rotate right at 16 clocks, then FS / SR2L / SR via the sequence button
    startScenario(4'b0011);
    expectR(base + 0,   4'b0001, "A reset state");
    expectR(base + 15,  4'b0001, "A before first tick");
    expectR(base + 16,  4'b1000, "A SR right 1");
    expectR(base + 32,  4'b0100, "A SR right 2");
    expectR(base + 48,  4'b0010, "A SR right 3");
    expectR(base + 50,  4'b0010, "A before press");
    expectR(base + 51,  4'b1111, "A FS seed on press");
    expectR(base + 63,  4'b1111, "A FS hold");
    expectR(base + 64,  4'b0000, "A FS toggle");
    expectR(base + 80,  4'b1111, "A FS toggle back");
    expectR(base + 86,  4'b1001, "A SR2L seed");
    expectR(base + 96,  4'b0110, "A SR2L inward");
    expectR(base + 112, 4'b1001, "A SR2L wrap");
    expectR(base + 116, 4'b0001, "A SR reseed");
    expectR(base + 128, 4'b1000, "A SR after reseed");
    expectR(base + 143, 4'b1000, "A before tick+press");
    expectR(base + 144, 4'b1111, "A reseed beats tick");
    expectR(base + 160, 4'b0000, "A FS after reseed");
    applyStimulus(base,       4'b0011, 4'b0000, 1'b0);
    applyStimulus(base + 50,  4'b0011, 4'b0001, 1'b0);
    applyStimulus(base + 51,  4'b0011, 4'b0000, 1'b0);
    applyStimulus(base + 85,  4'b0011, 4'b0001, 1'b0);
    applyStimulus(base + 86,  4'b0011, 4'b0000, 1'b0);
    applyStimulus(base + 115, 4'b0011, 4'b0001, 1'b0);
    applyStimulus(base + 116, 4'b0011, 4'b0000, 1'b0);
    applyStimulus(base + 143, 4'b0011, 4'b0001, 1'b0);
    applyStimulus(base + 144, 4'b0011, 4'b0000, 1'b0);
    drain();

    // Enable off freezes pattern and count; then rates 32/64 and a lowered limit
    startScenario(4'b0001);
    expectR(base + 0,   4'b0001, "B reset state");
    expectR(base + 8,   4'b1000, "B rate0 tick 1");
    expectR(base + 16,  4'b0100, "B rate0 tick 2");
    expectR(base + 21,  4'b0100, "B frozen start");
    expectR(base + 150, 4'b0100, "B frozen end");
    expectR(base + 177, 4'b0100, "B rate2 before resume tick");
    expectR(base + 178, 4'b0010, "B rate2 resume tick");
    expectR(base + 209, 4'b0010, "B rate2 before tick");
    expectR(base + 210, 4'b0001, "B rate2 period 32");
    expectR(base + 273, 4'b0001, "B rate3 before tick");
    expectR(base + 274, 4'b1000, "B rate3 period 64");
    expectR(base + 300, 4'b1000, "B before lowered limit");
    expectR(base + 301, 4'b0100, "B lowered limit fires");
    expectR(base + 308, 4'b0100, "B rate0 before tick");
    expectR(base + 309, 4'b0010, "B rate0 period 8");
    applyStimulus(base,       4'b0001, 4'b0000, 1'b0);
    applyStimulus(base + 20,  4'b0000, 4'b0000, 1'b0);
    applyStimulus(base + 150, 4'b0101, 4'b0000, 1'b0);
    applyStimulus(base + 211, 4'b0111, 4'b0000, 1'b0);
    applyStimulus(base + 300, 4'b0001, 4'b0000, 1'b0);
    drain();

    // Rotate left, then reverse from the current position
    startScenario(4'b1001);
    expectR(base + 0,  4'b0001, "C reset state");
    expectR(base + 8,  4'b0010, "C SR left 1");
    expectR(base + 16, 4'b0100, "C SR left 2");
    expectR(base + 24, 4'b1000, "C SR left 3");
    expectR(base + 32, 4'b0100, "C reversed 1");
    expectR(base + 40, 4'b0010, "C reversed 2");
    applyStimulus(base,      4'b1001, 4'b0000, 1'b0);
    applyStimulus(base + 26, 4'b0001, 4'b0000, 1'b0);
    drain();

    // Colour selection and held buttons, counter disabled
    startScenario(4'b0000);
    expectAt(base + 0,  4'b0001, 4'b0001, 4'b0000, 4'b0000, "D reset colour R");
    expectAt(base + 3,  4'b0001, 4'b0000, 4'b0001, 4'b0000, "D green select");
    expectAt(base + 6,  4'b0001, 4'b0000, 4'b0001, 4'b0000, "D green held");
    expectAt(base + 7,  4'b0001, 4'b0000, 4'b0000, 4'b0001, "D blue select");
    expectAt(base + 10, 4'b0001, 4'b0001, 4'b0001, 4'b0001, "D all colours");
    expectAt(base + 12, 4'b0001, 4'b0001, 4'b0001, 4'b0001, "D colour kept");
    expectAt(base + 21, 4'b1111, 4'b1111, 4'b1111, 4'b1111, "D FS seed");
    expectAt(base + 22, 4'b1111, 4'b1111, 4'b1111, 4'b1111, "D held next once");
    expectAt(base + 39, 4'b1111, 4'b1111, 4'b1111, 4'b1111, "D held next long");
    expectAt(base + 45, 4'b1111, 4'b0000, 4'b1111, 4'b0000, "D green only");
    expectAt(base + 48, 4'b1111, 4'b1111, 4'b1111, 4'b0000, "D red joins held green");
    applyStimulus(base,      4'b0000, 4'b0000, 1'b0);
    applyStimulus(base + 2,  4'b0000, 4'b0100, 1'b0);
    applyStimulus(base + 6,  4'b0000, 4'b1000, 1'b0);
    applyStimulus(base + 9,  4'b0000, 4'b1110, 1'b0);
    applyStimulus(base + 10, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(base + 20, 4'b0000, 4'b0001, 1'b0);
    applyStimulus(base + 40, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(base + 44, 4'b0000, 4'b0100, 1'b0);
    applyStimulus(base + 47, 4'b0000, 4'b0110, 1'b0);
    applyStimulus(base + 48, 4'b0000, 4'b0000, 1'b0);
    drain();

    // Simultaneous sequence + colour press, then reset in the middle of a run
    startScenario(4'b0000);
    expectAt(base + 0,   4'b0001, 4'b0001, 4'b0000, 4'b0000, "E reset state");
    expectAt(base + 3,   4'b1111, 4'b1111, 4'b0000, 4'b1111, "E combined press");
    expectAt(base + 65,  4'b1111, 4'b1111, 4'b0000, 4'b1111, "E before 64-clock tick");
    expectAt(base + 66,  4'b0000, 4'b0000, 4'b0000, 4'b0000, "E 64-clock tick");
    expectAt(base + 71,  4'b0001, 4'b0001, 4'b0000, 4'b0000, "E mid-run reset");
    expectAt(base + 134, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "E count restarted");
    expectAt(base + 135, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "E first tick after reset");
    applyStimulus(base,      4'b0000, 4'b0000, 1'b0);
    applyStimulus(base + 2,  4'b0111, 4'b1011, 1'b0);
    applyStimulus(base + 3,  4'b0111, 4'b0000, 1'b0);
    applyStimulus(base + 70, 4'b0111, 4'b0000, 1'b1);
    applyStimulus(base + 71, 4'b0111, 4'b0000, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/led_seq_top.md
Name: led_seq_top

Overview:
- Top-level LED pattern generator for a 4-switch/4-button/4-LED RGB board.
- A prescaler counter produces a step tick at one of four switch-selected rates.
- Each tick advances one of three patterns: SR (rotating single LED), FS (flash all), or SR2L (mirrored LED pair).
- The pattern drives a plain LED bank and, gated by a button-selected colour mask, the R/G/B LED banks.

Parameters:
- n_SW, 4, switch input width (fixed usage of 4 bits).
- n_BTN, 4, button input width (fixed usage of 4 bits).
- n_LEDS, 4, LEDs per bank; must be even and >= 4.
- n_COUNT, 32, prescaler counter width; 13 for simulation.

Ports:
- i_clk, input, 1, system clock; all logic on rising edge.
- i_reset, input, 1, synchronous reset, active-high.
- i_sw, input, n_SW: [0] = count enable, [2:1] = rate select, [3] = direction.
- i_btn, input, n_BTN: [0] = next sequence, [1] = red, [2] = green, [3] = blue.
- o_led, output, n_LEDS, current pattern.
- o_led_r, output, n_LEDS, pattern when red selected, else 0.
- o_led_g, output, n_LEDS, pattern when green selected, else 0.
- o_led_b, output, n_LEDS, pattern when blue selected, else 0.

Behaviour:
- Reset values: count=0, seq=SR, pattern=0…01, colour=R only, button history=0.
- Outputs after reset: o_led=0001, o_led_r=0001, o_led_g=o_led_b=0000. All outputs are registered.
- Limits: LIMIT_k = 2^(n_COUNT-10+k) - 1 for k=0..3, selected by i_sw[2:1]. With n_COUNT=13 the values are 7/15/31/63.
- Counter, i_sw[0]=1: count increments each cycle. When count >= limit: tick=1 for one cycle, count<=0.
- The >= compare means a lowered limit fires on the next cycle.
- Counter, i_sw[0]=0: count holds, no ticks, pattern frozen.
- Button edges: btn_q <= i_btn every cycle; rise = i_btn & ~btn_q.
  - A held button acts once.
  - Response is at the first clock edge sampling it high.
- rise[0] steps seq: SR -> FS -> SR2L -> SR.
  - On the step, pattern is loaded immediately with the new sequence's seed, regardless of tick.
  - Seeds: SR = 0…01, FS = 1…1, SR2L = 1 at both outermost bits (1001 for 4 LEDs).
- Colour: if any of rise[3:1] is set, colour <= i_btn[3:1], i.e. all buttons currently high.
  - Example: i_btn=1011 gives R+B.
  - The colour mask never goes to 000 by this path.
- On tick, SR with i_sw[3]=0 (right): rotate toward LSB, 0001->1000->0100->0010.
- On tick, SR with i_sw[3]=1 (left): rotate toward MSB, 0001->0010->0100->1000.
- On tick, FS: pattern <= ~pattern (1111 <-> 0000).
- On tick, SR2L: the pair moves one step.
  - i_sw[3]=0: toward centre, wrapping to the outermost pair after reaching the centre.
  - i_sw[3]=1: outward, wrapping to the centre pair.
  - For 4 LEDs both directions alternate 1001 <-> 0110.
- A direction change takes effect at the next tick without reseeding.
- Simultaneous tick and rise[0]: the reseed wins.
- Simultaneous colour and sequence presses are both applied.
- Reset mid-operation returns every register to its reset value on the next edge.
- RGB outputs: o_led_x = pattern & {n_LEDS{colour_x}}; o_led = pattern.

Optional Feature:
- Macro: LED_SEQ_INPUT_SYNC_EN.
- When defined: i_sw and i_btn pass through a 2-flop synchroniser before use, adding 2 cycles to all button and switch responses.
- When undefined: inputs are used directly, with the latency stated above.

Decomposition:
- Package led_seq_pkg holds:
  - sequence encoding SEQ_SR=2'b00, SEQ_FS=2'b01, SEQ_SR2L=2'b10;
  - colour bit indices;
  - the limit formula as a function of n_COUNT and rate select.
- One sub-module, led_seq_tick_counter: counter, limit mux and enable; outputs the one-cycle tick.

Test Plan (n_COUNT=13, n_LEDS=4):
- Reset, then sw=0011 (rate R1 = tick every 16 clocks, direction right): o_led 0001->1000->0100->0010, one step per 16 clocks; o_led_r follows; g/b=0.
- Pulse btn=0001 twice over separate windows: FS alternates 1111/0000 every 16 clocks, then SR2L alternates 1001/0110. A third pulse gives SR reseeded to 0001 on the press edge.
- sw=0010 (enable off): o_led frozen for 100+ clocks. sw=0001/0011/0101/0111: step periods 8/16/32/64 clocks.
- SR with sw=1001: 0001->0010->0100->1000. sw=0001 reverses from the current position.
- btn=0100 then 1000: only o_led_g, then only o_led_b, mirror o_led. btn=1110: all three banks mirror. A held button changes colour once only.
- Combined: sw=0111, btn=1011 in one cycle: seq=FS seeded 1111, colour R+B, 64-clock period. Assert i_reset mid-run: the next edge returns o_led=0001, colour=R.
